// File: rtl/mem_wb_stage_if.sv
// Bundle between the execute stage, the memory/writeback stage, the data
// memory and the register file. The stage is the slave; the surrounding
// environment (execute stage, memory, register file) is the master side.
//
// Handshakes:
//   - Instruction: a transfer happens on a rising edge where in_valid and
//     in_ready are both high. in_valid must be held until then.
//   - Memory request: dmem_req stays high with we/addr/be/wdata stable until
//     the rising edge where dmem_gnt is high. Load data arrives later on the
//     first edge with dmem_rvalid high, never in the cycle of its grant.
interface mem_wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int RNUM_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic                wb_reg;
    logic [RNUM_W-1:0]   rd_num;
    logic [XLEN-1:0]     alu_out;
    logic [XLEN-1:0]     store_data;

    logic                dmem_req;
    logic                dmem_we;
    logic [XLEN-1:0]     dmem_addr;
    logic [XLEN/8-1:0]   dmem_be;
    logic [XLEN-1:0]     dmem_wdata;
    logic                dmem_gnt;
    logic                dmem_rvalid;
    logic [XLEN-1:0]     dmem_rdata;

    logic                wb_enable;
    logic [RNUM_W-1:0]   wb_rd_num;
    logic [XLEN-1:0]     wb_rd_data;
    logic                done;
    logic                err;

    modport slave (
        input  in_valid, opcode, func3, wb_reg, rd_num, alu_out, store_data,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output in_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output wb_enable, wb_rd_num, wb_rd_data, done, err
    );

    modport master (
        output in_valid, opcode, func3, wb_reg, rd_num, alu_out, store_data,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  in_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  wb_enable, wb_rd_num, wb_rd_data, done, err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage. Accepts one instruction at a time,
// performs loads/stores against a data memory with variable grant and
// response latency, formats load data and emits a one-cycle writeback.
// Every output is driven straight from a register.
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int RNUM_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_stage_if.slave    bus,
    output logic [1:0]       dbg_state_o
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_q;

    // Registered outputs
    logic                in_ready_q;
    logic                dmem_req_q;
    logic                dmem_we_q;
    logic [XLEN-1:0]     dmem_addr_q;
    logic [NB-1:0]       dmem_be_q;
    logic [XLEN-1:0]     dmem_wdata_q;
    logic                wb_enable_q;
    logic [RNUM_W-1:0]   wb_rd_num_q;
    logic [XLEN-1:0]     wb_rd_data_q;
    logic                done_q;
    logic                err_q;

    // Instruction context latched at acceptance
    logic                is_load_q;
    logic                wb_reg_q;
    logic [RNUM_W-1:0]   rd_num_q;
    logic [2:0]          func3_q;
    logic [OFF_W-1:0]    off_q;

    // Decode of the presented instruction
    logic                is_load_d;
    logic                is_store_d;
    logic [1:0]          sz_log_d;
    logic                size_ok_d;
    logic [2:0]          align_mask_d;
    logic                misalign_d;
    logic                acc_err_d;
    logic [OFF_W-1:0]    off_d;
    logic [XLEN-1:0]     addr_d;
    logic [NB-1:0]       be_d;
    logic [XLEN-1:0]     wdata_d;

    // Load data formatting
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     load_fmt;

    assign off_d  = bus.alu_out[OFF_W-1:0];
    assign addr_d = {bus.alu_out[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    // Access size, legality and alignment of the presented instruction
    always_comb begin
        is_load_d  = (bus.opcode == OPC_LOAD);
        is_store_d = (bus.opcode == OPC_STORE);
        sz_log_d   = 2'd0;
        size_ok_d  = 1'b0;
        case (bus.func3)
            3'b000: begin sz_log_d = 2'd0; size_ok_d = 1'b1;                      end
            3'b001: begin sz_log_d = 2'd1; size_ok_d = 1'b1;                      end
            3'b010: begin sz_log_d = 2'd2; size_ok_d = 1'b1;                      end
            3'b011: begin sz_log_d = 2'd3; size_ok_d = (XLEN == 64);              end
            3'b100: begin sz_log_d = 2'd0; size_ok_d = is_load_d;                 end
            3'b101: begin sz_log_d = 2'd1; size_ok_d = is_load_d;                 end
            3'b110: begin sz_log_d = 2'd2; size_ok_d = is_load_d && (XLEN == 64); end
            default: begin sz_log_d = 2'd0; size_ok_d = 1'b0;                     end
        endcase
        case (sz_log_d)
            2'd0:    align_mask_d = 3'b000;
            2'd1:    align_mask_d = 3'b001;
            2'd2:    align_mask_d = 3'b011;
            default: align_mask_d = 3'b111;
        endcase
        misalign_d = |(off_d & align_mask_d[OFF_W-1:0]);
        acc_err_d  = (is_load_d || is_store_d) && (!size_ok_d || misalign_d);
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_d    = '0;
        wdata_d = '0;
        for (int i = 0; i < NB; i++) begin
            be_d[i] = (i >= int'(off_d)) && (i < int'(off_d) + (1 << sz_log_d));
            wdata_d[i*8 +: 8] = bus.store_data[(i & ((1 << sz_log_d) - 1))*8 +: 8];
        end
    end

    // Align returned data to bit 0, then sign- or zero-extend by access size
    always_comb begin
        shifted  = bus.dmem_rdata >> {off_q, 3'b000};
        load_fmt = shifted;
        case (func3_q)
            3'b000:  load_fmt = XLEN'($signed(shifted[7:0]));
            3'b001:  load_fmt = XLEN'($signed(shifted[15:0]));
            3'b010:  load_fmt = XLEN'($signed(shifted[31:0]));
            3'b100:  load_fmt = XLEN'(shifted[7:0]);
            3'b101:  load_fmt = XLEN'(shifted[15:0]);
            3'b110:  load_fmt = XLEN'(shifted[31:0]);
            default: load_fmt = shifted;
        endcase
    end

    // Control FSM with all outputs registered; WB pulses are set on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_enable_q  <= 1'b0;
            wb_rd_num_q  <= '0;
            wb_rd_data_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            is_load_q    <= 1'b0;
            wb_reg_q     <= 1'b0;
            rd_num_q     <= '0;
            func3_q      <= '0;
            off_q        <= '0;
        end else begin
            done_q      <= 1'b0;
            wb_enable_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        is_load_q  <= is_load_d;
                        wb_reg_q   <= bus.wb_reg;
                        rd_num_q   <= bus.rd_num;
                        func3_q    <= bus.func3;
                        off_q      <= off_d;
                        if ((is_load_d || is_store_d) && !acc_err_d) begin
                            state_q      <= S_REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= is_store_d;
                            dmem_addr_q  <= addr_d;
                            dmem_be_q    <= be_d;
                            dmem_wdata_q <= wdata_d;
                        end else begin
                            state_q <= S_WB;
                            done_q  <= 1'b1;
                            err_q   <= acc_err_d;
                            if (!acc_err_d) begin
                                wb_enable_q  <= bus.wb_reg && (bus.rd_num != '0);
                                wb_rd_num_q  <= bus.rd_num;
                                wb_rd_data_q <= bus.alu_out;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        dmem_be_q  <= '0;
                        if (is_load_q) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_WB;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_rvalid) begin
                        state_q      <= S_WB;
                        done_q       <= 1'b1;
                        wb_enable_q  <= wb_reg_q && (rd_num_q != '0);
                        wb_rd_num_q  <= rd_num_q;
                        wb_rd_data_q <= load_fmt;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.wb_enable  = wb_enable_q;
    assign bus.wb_rd_num  = wb_rd_num_q;
    assign bus.wb_rd_data = wb_rd_data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage (XLEN=32): directed scenarios plus
// randomized instructions against a byte-level behavioural model of the
// stage and a 16-word data memory.
module tb_mem_wb_stage;
    localparam int XLEN   = 32;
    localparam int RNUM_W = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.XLEN(XLEN), .RNUM_W(RNUM_W)) bus ();

    mem_wb_stage #(.XLEN(XLEN), .RNUM_W(RNUM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [31:0] mem [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Derives the architectural outcome of one instruction from the access
    // rules: size in bytes, signedness, legality, alignment, lanes.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic wbr,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] sd,
                         output bit is_ld, output bit is_st, output bit e, output bit en,
                         output logic [31:0] data, output logic [3:0] be,
                         output logic [31:0] wd);
        int nbytes;
        bit sgn;
        bit legal;
        int off;
        longint v;
        longint mask;
        is_ld  = (op == OPC_LOAD);
        is_st  = (op == OPC_STORE);
        nbytes = 1;
        sgn    = 1'b0;
        legal  = 1'b0;
        if (is_ld) begin
            case (f3)
                3'd0: begin nbytes = 1; sgn = 1; legal = 1; end
                3'd1: begin nbytes = 2; sgn = 1; legal = 1; end
                3'd2: begin nbytes = 4; sgn = 1; legal = 1; end
                3'd4: begin nbytes = 1; sgn = 0; legal = 1; end
                3'd5: begin nbytes = 2; sgn = 0; legal = 1; end
                default: legal = 0;
            endcase
        end else if (is_st) begin
            case (f3)
                3'd0: begin nbytes = 1; legal = 1; end
                3'd1: begin nbytes = 2; legal = 1; end
                3'd2: begin nbytes = 4; legal = 1; end
                default: legal = 0;
            endcase
        end
        off = int'(a % 4);
        e   = (is_ld || is_st) && (!legal || (a % nbytes) != 0);
        be  = 4'(((1 << nbytes) - 1) << off);
        for (int i = 0; i < 4; i++) wd[i*8 +: 8] = sd[(i % nbytes)*8 +: 8];
        v    = longint'(mem[(a >> 2) & 15]) >> (8 * off);
        mask = (longint'(1) << (8 * nbytes)) - 1;
        v    = v & mask;
        if (sgn && ((v >> (8 * nbytes - 1)) & 1) != 0) v = v | ~mask;
        en   = !e && !is_st && wbr && (rd != 0);
        data = is_ld ? 32'(v) : a;
    endtask

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.opcode      = 7'($urandom);
        bus.func3       = 3'($urandom);
        bus.wb_reg      = 1'($urandom);
        bus.rd_num      = 5'($urandom);
        bus.alu_out     = $urandom;
        bus.store_data  = $urandom;
    endtask

    // Issue one instruction, act as the memory (grant after gw REQ cycles,
    // rvalid rg cycles after the grant) and check the whole transaction.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic wbr,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] sd,
                       input int gw, input int rg);
        bit is_ld, is_st, e, en;
        logic [31:0] data, wd, exp_data;
        logic [3:0] be;
        int lat, k, req_cnt, gnt_k;
        bit saw_req, done_seen;
        model(op, f3, wbr, rd, a, sd, is_ld, is_st, e, en, data, be, wd);
        exp_q.push_back(data);
        if (e || !(is_ld || is_st)) lat = 1;
        else if (is_st)             lat = 2 + gw;
        else                        lat = 3 + gw + (rg - 1);

        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_valid   = 1'b1;
        bus.opcode     = op;
        bus.func3      = f3;
        bus.wb_reg     = wbr;
        bus.rd_num     = rd;
        bus.alu_out    = a;
        bus.store_data = sd;
        @(posedge clk);

        k = 0; req_cnt = 0; gnt_k = -1; saw_req = 0; done_seen = 0;
        while (!done_seen && k < 60) begin
            @(negedge clk);
            k++;
            idle_inputs();
            bus.dmem_gnt    = 1'b0;
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata  = $urandom;
            if (k == 1) check("in_ready_busy", bus.in_ready, 1'b0);
            if (bus.dmem_req) begin
                saw_req = 1;
                check("req_addr", bus.dmem_addr, a & 32'hFFFF_FFFC);
                check("req_be", bus.dmem_be, be);
                check("req_we", bus.dmem_we, is_st);
                if (is_st) check("req_wdata", bus.dmem_wdata, wd);
                if (req_cnt == gw) begin
                    bus.dmem_gnt = 1'b1;
                    gnt_k = k;
                    if (is_st)
                        for (int i = 0; i < 4; i++)
                            if (be[i]) mem[(a >> 2) & 15][i*8 +: 8] = wd[i*8 +: 8];
                end
                req_cnt++;
            end else if (gnt_k < 0 && !bus.done) begin
                bus.dmem_gnt = 1'($urandom);
            end
            if (is_ld && gnt_k > 0 && k == gnt_k + rg) begin
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = mem[(a >> 2) & 15];
            end
            if (bus.done) begin
                done_seen = 1;
                exp_data = exp_q.pop_front();
                check("wb_latency", 64'(k), 64'(lat));
                check("err", bus.err, e);
                check("wb_enable", bus.wb_enable, en);
                check("mem_access", saw_req, (is_ld || is_st) && !e);
                if (en) begin
                    check("wb_rd_num", bus.wb_rd_num, rd);
                    check("wb_rd_data", bus.wb_rd_data, exp_data);
                end
            end
        end
        if (!done_seen) begin
            check("done_timeout", 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        check("done_pulse", bus.done, 1'b0);
        check("wb_enable_pulse", bus.wb_enable, 1'b0);
        check("in_ready_back", bus.in_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check({tag, "_req"}, bus.dmem_req, 1'b0);
        check({tag, "_we"}, bus.dmem_we, 1'b0);
        check({tag, "_addr"}, bus.dmem_addr, 0);
        check({tag, "_be"}, bus.dmem_be, 0);
        check({tag, "_wdata"}, bus.dmem_wdata, 0);
        check({tag, "_wb_en"}, bus.wb_enable, 1'b0);
        check({tag, "_rd_num"}, bus.wb_rd_num, 0);
        check({tag, "_rd_data"}, bus.wb_rd_data, 0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] ops [6];
        ops[0] = OPC_LOAD; ops[1] = OPC_STORE; ops[2] = OPC_OP;
        ops[3] = OPC_IMM;  ops[4] = OPC_LUI;   ops[5] = OPC_BR;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h8081_82F3;
        mem[1] = 32'hC3D2_E1F0;

        rst = 1'b1;
        idle_inputs();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed scenarios
        run(OPC_LOAD, 3'b000, 1, 5'd1, 32'h0001_0000, 32'h0, 0, 1);  // LB
        run(OPC_LOAD, 3'b100, 1, 5'd2, 32'h0001_0001, 32'h0, 0, 1);  // LBU
        run(OPC_LOAD, 3'b001, 1, 5'd3, 32'h0001_0002, 32'h0, 0, 1);  // LH
        run(OPC_LOAD, 3'b101, 1, 5'd4, 32'h0001_0002, 32'h0, 0, 1);  // LHU
        run(OPC_LOAD, 3'b010, 1, 5'd5, 32'h0001_0000, 32'h0, 0, 1);  // LW
        run(OPC_LOAD, 3'b010, 1, 5'd6, 32'h0001_0002, 32'h0, 0, 1);  // LW misaligned
        run(OPC_LOAD, 3'b011, 1, 5'd7, 32'h0001_0000, 32'h0, 0, 1);  // LD illegal
        run(OPC_LOAD, 3'b110, 1, 5'd7, 32'h0001_0000, 32'h0, 0, 1);  // LWU illegal
        run(OPC_STORE, 3'b000, 1, 5'd1, 32'h0001_0003, 32'h1234_56AB, 0, 1); // SB
        run(OPC_STORE, 3'b001, 1, 5'd1, 32'h0001_0002, 32'h1234_56AB, 0, 1); // SH
        run(OPC_STORE, 3'b010, 1, 5'd1, 32'h0001_0001, 32'h1234_56AB, 0, 1); // SW misaligned
        run(OPC_STORE, 3'b100, 1, 5'd1, 32'h0001_0000, 32'h1234_56AB, 0, 1); // illegal store size
        run(OPC_LOAD, 3'b010, 1, 5'd8, 32'h0001_0000, 32'h0, 0, 1);  // reads the stores back
        run(OPC_OP, 3'b000, 1, 5'd1, 32'h0001_0000, 32'h0, 0, 1);
        run(OPC_OP, 3'b000, 1, 5'd0, 32'h0001_0000, 32'h0, 0, 1);
        run(OPC_LOAD, 3'b010, 1, 5'd9, 32'h0001_0004, 32'h0, 3, 2);  // delayed gnt/rvalid

        // Reset during WAIT, then a stray rvalid
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opcode = OPC_LOAD; bus.func3 = 3'b010;
        bus.wb_reg = 1'b1; bus.rd_num = 5'd3; bus.alu_out = 32'h0001_0000;
        @(negedge clk);                      // REQ
        idle_inputs();
        check("rst_req_seen", bus.dmem_req, 1'b1);
        bus.dmem_gnt = 1'b1;
        @(negedge clk);                      // WAIT
        bus.dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        check("stray_done", bus.done, 1'b0);
        check("stray_wb_en", bus.wb_enable, 1'b0);
        check("stray_in_ready", bus.in_ready, 1'b1);
        run(OPC_IMM, 3'b000, 1, 5'd12, 32'h0000_0ABC, 32'h0, 0, 1);

        // Randomized instructions
        for (int n = 0; n < 200; n++) begin
            run(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 31)), 32'h0001_0000 + $urandom_range(0, 63),
                $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
